// File: rtl/anita3_trig_pkg.sv
// Shared trigger-path definitions: hold-buffer indices and the buffer-manager FSM encoding
// that the event generator also decodes.
package anita3_trig_pkg;

  localparam int unsigned NBUF = 4;

  localparam logic [1:0] BUF_A = 2'd0;
  localparam logic [1:0] BUF_B = 2'd1;
  localparam logic [1:0] BUF_C = 2'd2;
  localparam logic [1:0] BUF_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStrobe  = 2'd1,
    StHoldoff = 2'd2
  } bm_state_e;

  function automatic logic [NBUF-1:0] buf_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/anita3_rr_pick.sv
// Round-robin free-buffer picker: first set bit of free_i scanning from ptr_i upward, mod 4.
module anita3_rr_pick
  import anita3_trig_pkg::*;
(
  input  logic [NBUF-1:0] free_i,
  input  logic [1:0]      ptr_i,
  output logic            found_o,
  output logic [1:0]      idx_o
);

  logic [1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int unsigned i = 0; i < NBUF; i++) begin
      cand = ptr_i + 2'(i);
      if (!found_o && free_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/anita3_buffer_manager.sv
// Hold-buffer manager: allocates LAB buffers on trigger, drives the stretched digitize strobe,
// frees buffers on readout release and keeps deadtime/dropped housekeeping counters.
module anita3_buffer_manager
  import anita3_trig_pkg::*;
#(
  parameter int unsigned DIGITIZE_LEN = 4,
  parameter int unsigned HOLDOFF      = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trig_i,
  input  logic [3:0]       trig_source_i,
  input  logic             release_i,
  input  logic [1:0]       release_buffer_i,
  input  logic             clr_all_i,
  input  logic             cnt_reset_i,
  output logic             digitize_o,
  output logic [1:0]       digitize_buffer_o,
  output logic [3:0]       digitize_source_o,
  output logic [NBUF-1:0]  buffer_status_o,
  output logic [NBUF-1:0]  held_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] deadtime_o,
  output logic [CNT_W-1:0] dropped_o,
  output logic             release_err_o
);

  localparam int unsigned TimerMax = (DIGITIZE_LEN > HOLDOFF) ? DIGITIZE_LEN : HOLDOFF;
  localparam int unsigned TimerW   = $clog2(TimerMax);
  localparam logic [TimerW-1:0] StrobeLast = TimerW'(DIGITIZE_LEN - 1);
  localparam logic [TimerW-1:0] HoldLast   = TimerW'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]  CntMax     = '1;

  bm_state_e         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [NBUF-1:0]   held_q, held_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        buf_q, buf_d;
  logic [3:0]        src_q, src_d;
  logic [NBUF-1:0]   status_q, status_d;
  logic [CNT_W-1:0]  dead_q, dead_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              err_q, err_d;

  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              accept, drop, rel_hit;
  logic [NBUF-1:0]   alloc_mask, rel_mask;

  // Allocation always sees the pre-release mask; a same-cycle release cannot feed this accept.
  anita3_rr_pick u_rr_pick (
    .free_i  (~held_q),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign accept     = trig_i && (state_q == StIdle) && pick_found && !clr_all_i;
  assign drop       = trig_i && !accept;
  assign rel_hit    = release_i && held_q[release_buffer_i];
  assign alloc_mask = accept ? buf_onehot(pick_idx) : '0;
  assign rel_mask   = rel_hit ? buf_onehot(release_buffer_i) : '0;

  always_comb begin
    held_d = (held_q | alloc_mask) & ~rel_mask;
    err_d  = err_q | (release_i && !rel_hit);
    if (clr_all_i) begin
      held_d = '0;
      err_d  = 1'b0;
    end

    dead_d = dead_q;
    drop_d = drop_q;
    if (cnt_reset_i) begin
      dead_d = '0;
      drop_d = '0;
    end else begin
      if ((&held_q) && (dead_q != CntMax)) dead_d = dead_q + CNT_W'(1);
      if (drop && (drop_q != CntMax))      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    buf_d    = buf_q;
    src_d    = src_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StStrobe;
          timer_d  = '0;
          ptr_d    = pick_idx + 2'd1;
          buf_d    = pick_idx;
          src_d    = trig_source_i;
          status_d = held_d;
        end
      end
      StStrobe: begin
        if (timer_q == StrobeLast) begin
          state_d = StHoldoff;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StHoldoff: begin
        if (timer_q == HoldLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
    if (clr_all_i) begin
      state_d = StIdle;
      timer_d = '0;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      held_q   <= '0;
      ptr_q    <= '0;
      buf_q    <= '0;
      src_q    <= '0;
      status_q <= '0;
      dead_q   <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      held_q   <= held_d;
      ptr_q    <= ptr_d;
      buf_q    <= buf_d;
      src_q    <= src_d;
      status_q <= status_d;
      dead_q   <= dead_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  // Decoded straight from state so an async reset drops the strobe without a clock edge.
  assign digitize_o        = (state_q == StStrobe);
  assign digitize_buffer_o = buf_q;
  assign digitize_source_o = src_q;
  assign buffer_status_o   = status_q;
  assign held_o            = held_q;
  assign busy_o            = &held_q;
  assign deadtime_o        = dead_q;
  assign dropped_o         = drop_q;
  assign release_err_o     = err_q;

endmodule

// File: tb/tb_anita3_buffer_manager.sv
// Scoreboard bench for anita3_buffer_manager: stimulus pushes expected strobes, a negedge
// monitor pops and checks them; housekeeping outputs are checked against hand-computed values.
module tb_anita3_buffer_manager;

  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            trig, release_v, clr_all, cnt_reset;
  logic [3:0]      trig_src;
  logic [1:0]      rel_buf;
  logic            dig, rel_err, busy;
  logic [1:0]      dig_buf;
  logic [3:0]      dig_src, status, held;
  logic [CntW-1:0] deadtime, dropped;

  typedef struct {
    logic [1:0] b;
    logic [3:0] s;
    logic [3:0] st;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  anita3_buffer_manager #(
    .DIGITIZE_LEN (4),
    .HOLDOFF      (8),
    .CNT_W        (CntW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .trig_i            (trig),
    .trig_source_i     (trig_src),
    .release_i         (release_v),
    .release_buffer_i  (rel_buf),
    .clr_all_i         (clr_all),
    .cnt_reset_i       (cnt_reset),
    .digitize_o        (dig),
    .digitize_buffer_o (dig_buf),
    .digitize_source_o (dig_src),
    .buffer_status_o   (status),
    .held_o            (held),
    .busy_o            (busy),
    .deadtime_o        (deadtime),
    .dropped_o         (dropped),
    .release_err_o     (rel_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] b, input logic [3:0] s, input logic [3:0] st,
                      input int len);
    exp_t e;
    e.b = b; e.s = s; e.st = st; e.len = len;
    exp_q.push_back(e);
  endtask

  // Issue one trigger that is expected to be accepted.
  task automatic trig_ok(input logic [3:0] src, input logic [1:0] b, input logic [3:0] st,
                         input int len);
    push(b, src, st, len);
    trig = 1'b1;
    trig_src = src;
    tick();
    trig = 1'b0;
  endtask

  // Monitor: pops one expectation per rising strobe and checks its length when it falls.
  logic prev_dig = 1'b0;
  int   run_len  = 0;
  int   cur_len  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_dig = 1'b0;
      run_len  = 0;
    end else begin
      if (dig && !prev_dig) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
          cur_len = 0;
        end else begin
          e = exp_q.pop_front();
          chk("strobe_buffer", 32'(dig_buf), 32'(e.b));
          chk("strobe_source", 32'(dig_src), 32'(e.s));
          chk("strobe_status", 32'(status), 32'(e.st));
          cur_len = e.len;
        end
        run_len = 1;
      end else if (dig) begin
        run_len++;
      end else if (prev_dig && cur_len != 0) begin
        chk("strobe_len", 32'(run_len), 32'(cur_len));
      end
      prev_dig = dig;
    end
  end

  initial begin
    rst = 1'b1; trig = 1'b0; trig_src = '0; release_v = 1'b0; rel_buf = '0;
    clr_all = 1'b0; cnt_reset = 1'b0;
    #2;
    chk("rst_digitize", 32'(dig), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_deadtime", 32'(deadtime), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_relerr", 32'(rel_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Four spaced triggers fill buffers 0..3 in order.
    trig_ok(4'hA, 2'd0, 4'b0001, 4); repeat (12) tick();
    trig_ok(4'h5, 2'd1, 4'b0011, 4); repeat (12) tick();
    trig_ok(4'hC, 2'd2, 4'b0111, 4); repeat (12) tick();
    trig_ok(4'h3, 2'd3, 4'b1111, 4); repeat (12) tick();
    chk("t1_held", 32'(held), 32'hF);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_deadtime", 32'(deadtime), 32'd12);

    // Trigger while full is dropped.
    trig = 1'b1; trig_src = 4'h6; tick(); trig = 1'b0;
    chk("t2_dropped", 32'(dropped), 32'd1);
    repeat (2) tick();
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_deadtime", 32'(deadtime), 32'd15);

    // Release buffer 2; ptr is 0, scan lands on 2.
    release_v = 1'b1; rel_buf = 2'd2; tick(); release_v = 1'b0;
    chk("t3_held_rel", 32'(held), 32'hB);
    chk("t3_busy_low", 32'(busy), 32'd0);
    trig_ok(4'h7, 2'd2, 4'b1111, 4);
    chk("t3_busy_high", 32'(busy), 32'd1);
    chk("t3_deadtime", 32'(deadtime), 32'd16);
    repeat (12) tick();
    chk("t3_deadtime_end", 32'(deadtime), 32'd28);

    // Mask 0111, then same-cycle release 0 + trigger allocates 3.
    release_v = 1'b1; rel_buf = 2'd3; tick(); release_v = 1'b0;
    chk("t5_held_0111", 32'(held), 32'h7);
    release_v = 1'b1; rel_buf = 2'd0;
    trig_ok(4'h9, 2'd3, 4'b1110, 4);
    release_v = 1'b0;
    chk("t5_held_1110", 32'(held), 32'hE);
    chk("t5_deadtime", 32'(deadtime), 32'd29);

    // Trigger 3 cycles into holdoff is dropped.
    repeat (6) tick();
    trig = 1'b1; trig_src = 4'h2; tick(); trig = 1'b0;
    chk("t4_dropped", 32'(dropped), 32'd2);
    chk("t4_held", 32'(held), 32'hE);
    chk("t4_relerr_clean", 32'(rel_err), 32'd0);

    release_v = 1'b1; rel_buf = 2'd0; tick(); release_v = 1'b0;
    chk("t5_relerr", 32'(rel_err), 32'd1);
    chk("t5_held_after_err", 32'(held), 32'hE);
    repeat (5) tick();

    // clr_all mid-strobe cuts it after two cycles.
    release_v = 1'b1; rel_buf = 2'd1; tick(); release_v = 1'b0;
    chk("t6_held_1100", 32'(held), 32'hC);
    trig_ok(4'hE, 2'd0, 4'b1101, 2);
    tick();
    clr_all = 1'b1; tick(); clr_all = 1'b0;
    chk("t6_clr_digitize", 32'(dig), 32'd0);
    chk("t6_clr_held", 32'(held), 32'd0);
    chk("t6_clr_relerr", 32'(rel_err), 32'd0);
    chk("t6_clr_dropped", 32'(dropped), 32'd2);
    chk("t6_clr_deadtime", 32'(deadtime), 32'd29);

    clr_all = 1'b1; trig = 1'b1; trig_src = 4'h1; tick(); clr_all = 1'b0; trig = 1'b0;
    chk("t6_clr_trig_drop", 32'(dropped), 32'd3);
    chk("t6_clr_trig_held", 32'(held), 32'd0);

    cnt_reset = 1'b1; tick(); cnt_reset = 1'b0;
    chk("cnt_reset_dropped", 32'(dropped), 32'd0);
    chk("cnt_reset_deadtime", 32'(deadtime), 32'd0);

    // Async reset mid-strobe.
    trig_ok(4'h5, 2'd0, 4'b0001, 0);
    tick();
    chk("t6_pre_rst_digitize", 32'(dig), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_digitize", 32'(dig), 32'd0);
    chk("t6_rst_held", 32'(held), 32'd0);
    chk("t6_rst_buffer", 32'(dig_buf), 32'd0);
    chk("t6_rst_source", 32'(dig_src), 32'd0);
    chk("t6_rst_status", 32'(status), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
